// File: rtl/io_sequencer.sv
// io_sequencer: stalls the core for IN/OUT/HALT and drives the
// 7-segment I/O block mode strobes, Enter debounce included.
module io_sequencer #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int OUT_HOLD_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_in,
  input  logic        instr_out,
  input  logic        instr_halt,
  input  logic        enter,
  input  logic [9:0]  sw,
  input  logic [31:0] out_value,
  output logic        stall,
  output logic        in_valid,
  output logic [31:0] input_data,
  output logic [31:0] out_latch,
  output logic        disp_input,
  output logic        disp_output,
  output logic        disp_halt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_IN_WAIT,
    S_IN_DONE,
    S_OUT_HOLD,
    S_HALTED
  } state_e;

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W =
    (OUT_HOLD_CYCLES > 1) ? $clog2(OUT_HOLD_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST =
    DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_INIT =
    HOLD_W'((OUT_HOLD_CYCLES > 0) ? OUT_HOLD_CYCLES - 1 : 0);

  logic              sync1_q, sync1_d;
  logic              sync2_q, sync2_d;
  logic              db_q, db_d;
  logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
  logic              press_q, press_d;
  state_e            state_q, state_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [31:0]       input_data_q, input_data_d;
  logic [31:0]       out_latch_q, out_latch_d;
  logic              disp_input_q, disp_input_d;
  logic              disp_output_q, disp_output_d;
  logic              disp_halt_q, disp_halt_d;
  logic              stall_c;

  // Debounced level flips only after a full run of disagreement.
  always_comb begin
    sync1_d  = enter;
    sync2_d  = sync1_q;
    db_d     = db_q;
    db_cnt_d = '0;
    press_d  = 1'b0;
    if (sync2_q != db_q) begin
      if (db_cnt_q == DB_LAST) begin
        db_d    = sync2_q;
        press_d = sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    hold_cnt_d    = hold_cnt_q;
    input_data_d  = input_data_q;
    out_latch_d   = out_latch_q;
    disp_input_d  = disp_input_q;
    disp_output_d = disp_output_q;
    disp_halt_d   = disp_halt_q;
    stall_c       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (instr_halt) begin
          stall_c       = 1'b1;
          disp_halt_d   = 1'b1;
          disp_input_d  = 1'b0;
          disp_output_d = 1'b0;
          state_d       = S_HALTED;
        end else if (instr_in) begin
          stall_c       = 1'b1;
          disp_input_d  = 1'b1;
          disp_output_d = 1'b0;
          disp_halt_d   = 1'b0;
          state_d       = S_IN_WAIT;
        end else if (instr_out) begin
          out_latch_d   = out_value;
          disp_output_d = 1'b1;
          disp_input_d  = 1'b0;
          if (OUT_HOLD_CYCLES > 0) begin
            stall_c    = 1'b1;
            hold_cnt_d = HOLD_INIT;
            state_d    = S_OUT_HOLD;
          end
        end
      end
      S_IN_WAIT: begin
        stall_c      = 1'b1;
        input_data_d = {22'b0, sw};
        if (press_q) begin
          state_d = S_IN_DONE;
        end
      end
      S_IN_DONE: begin
        state_d = S_IDLE;
      end
      S_OUT_HOLD: begin
        if (hold_cnt_q != '0) begin
          stall_c    = 1'b1;
          hold_cnt_d = hold_cnt_q - 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_HALTED: begin
        stall_c = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q       <= 1'b0;
      sync2_q       <= 1'b0;
      db_q          <= 1'b0;
      db_cnt_q      <= '0;
      press_q       <= 1'b0;
      state_q       <= S_IDLE;
      hold_cnt_q    <= '0;
      input_data_q  <= '0;
      out_latch_q   <= '0;
      disp_input_q  <= 1'b0;
      disp_output_q <= 1'b0;
      disp_halt_q   <= 1'b0;
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      db_q          <= db_d;
      db_cnt_q      <= db_cnt_d;
      press_q       <= press_d;
      state_q       <= state_d;
      hold_cnt_q    <= hold_cnt_d;
      input_data_q  <= input_data_d;
      out_latch_q   <= out_latch_d;
      disp_input_q  <= disp_input_d;
      disp_output_q <= disp_output_d;
      disp_halt_q   <= disp_halt_d;
    end
  end

  assign stall       = stall_c & ~reset;
  assign in_valid    = (state_q == S_IN_DONE) & ~reset;
  assign input_data  = input_data_q;
  assign out_latch   = out_latch_q;
  assign disp_input  = disp_input_q;
  assign disp_output = disp_output_q;
  assign disp_halt   = disp_halt_q;

endmodule

// File: tb/tb_io_sequencer.sv
// Random and directed bench for io_sequencer: two instances
// (OUT hold 3 and 0) checked each cycle against a behavioural model.
module tb_io_sequencer;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_in, instr_out, instr_halt;
  logic        enter;
  logic [9:0]  sw;
  logic [31:0] out_value;

  logic [1:0]  stall_o, iv_o, di_o, do_o, dh_o;
  logic [31:0] indata_o [2];
  logic [31:0] latch_o [2];

  int n_chk = 0;
  int n_fail = 0;

  int hold_len [2] = '{3, 0};

  bit          m_wait [2];
  bit          m_done [2];
  bit          m_halted [2];
  int          m_orem [2];
  logic [31:0] m_data [2];
  logic [31:0] m_latch [2];
  bit          m_di [2];
  bit          m_do [2];
  bit          m_dh [2];
  bit          hist [$];
  bit          m_db;
  bit          m_press;

  int iv_cnt [2];
  int st_cnt [2];
  int low_cnt [2];
  bit seen_low [2];
  bit first_low_iv [2];

  always #5 clk = ~clk;

  io_sequencer #(.DEBOUNCE_CYCLES(N), .OUT_HOLD_CYCLES(3)) u_a (
    .clk(clk), .reset(reset),
    .instr_in(instr_in), .instr_out(instr_out),
    .instr_halt(instr_halt), .enter(enter),
    .sw(sw), .out_value(out_value),
    .stall(stall_o[0]), .in_valid(iv_o[0]),
    .input_data(indata_o[0]), .out_latch(latch_o[0]),
    .disp_input(di_o[0]), .disp_output(do_o[0]),
    .disp_halt(dh_o[0])
  );

  io_sequencer #(.DEBOUNCE_CYCLES(N), .OUT_HOLD_CYCLES(0)) u_b (
    .clk(clk), .reset(reset),
    .instr_in(instr_in), .instr_out(instr_out),
    .instr_halt(instr_halt), .enter(enter),
    .sw(sw), .out_value(out_value),
    .stall(stall_o[1]), .in_valid(iv_o[1]),
    .input_data(indata_o[1]), .out_latch(latch_o[1]),
    .disp_input(di_o[1]), .disp_output(do_o[1]),
    .disp_halt(dh_o[1])
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit exp_stall(input int i);
    if (reset) return 1'b0;
    if (m_halted[i] || m_wait[i]) return 1'b1;
    if (m_done[i]) return 1'b0;
    if (m_orem[i] > 0) return m_orem[i] > 1;
    return instr_halt || instr_in ||
           (instr_out && hold_len[i] > 0);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      m_wait[i] = 0; m_done[i] = 0; m_halted[i] = 0;
      m_orem[i] = 0; m_data[i] = '0; m_latch[i] = '0;
      m_di[i] = 0; m_do[i] = 0; m_dh[i] = 0;
    end
    hist.delete();
    for (int j = 0; j < N + 2; j++) hist.push_back(1'b0);
    m_db = 0;
    m_press = 0;
  endtask

  task automatic model_edge();
    bit flip;
    if (reset) begin
      model_clear();
      return;
    end
    for (int i = 0; i < 2; i++) begin
      if (m_halted[i]) begin
      end else if (m_wait[i]) begin
        m_data[i] = {22'b0, sw};
        if (m_press) begin
          m_wait[i] = 0;
          m_done[i] = 1;
        end
      end else if (m_done[i]) begin
        m_done[i] = 0;
      end else if (m_orem[i] > 0) begin
        m_orem[i]--;
      end else if (instr_halt) begin
        m_halted[i] = 1;
        m_dh[i] = 1; m_di[i] = 0; m_do[i] = 0;
      end else if (instr_in) begin
        m_wait[i] = 1;
        m_di[i] = 1; m_do[i] = 0; m_dh[i] = 0;
      end else if (instr_out) begin
        m_latch[i] = out_value;
        m_do[i] = 1; m_di[i] = 0;
        m_orem[i] = hold_len[i];
      end
    end
    // Enter seen two samples late; flips after N opposite samples.
    hist.push_front(enter);
    void'(hist.pop_back());
    flip = 1;
    for (int j = 2; j < N + 2; j++)
      if (hist[j] == m_db) flip = 0;
    m_press = flip && !m_db;
    if (flip) m_db = !m_db;
  endtask

  task automatic clr_counters();
    for (int i = 0; i < 2; i++) begin
      iv_cnt[i] = 0; st_cnt[i] = 0; low_cnt[i] = 0;
      seen_low[i] = 0; first_low_iv[i] = 0;
    end
  endtask

  task automatic step();
    logic [4:0] ef;
    #1;
    for (int i = 0; i < 2; i++) begin
      ef = {exp_stall(i), !reset && m_done[i],
            m_di[i], m_do[i], m_dh[i]};
      chk($sformatf("flags%0d", i),
          {27'b0, stall_o[i], iv_o[i], di_o[i], do_o[i], dh_o[i]},
          {27'b0, ef});
      chk($sformatf("input_data%0d", i), indata_o[i], m_data[i]);
      chk($sformatf("out_latch%0d", i), latch_o[i], m_latch[i]);
      if (iv_o[i] === 1'b1) iv_cnt[i]++;
      if (stall_o[i] === 1'b1) st_cnt[i]++;
      else begin
        low_cnt[i]++;
        if (!seen_low[i]) first_low_iv[i] = iv_o[i];
        seen_low[i] = 1;
      end
    end
    model_edge();
    @(negedge clk);
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic issue(input int kind);
    instr_in   = (kind == 0);
    instr_out  = (kind == 1);
    instr_halt = (kind == 2);
    step();
    instr_in = 0; instr_out = 0; instr_halt = 0;
  endtask

  initial begin
    int hold;
    reset = 1; instr_in = 0; instr_out = 0; instr_halt = 0;
    enter = 0; sw = '0; out_value = '0;
    repeat (2) @(negedge clk);
    model_clear();
    steps(2);
    reset = 0;
    steps(3);

    // IN completed by a clean Enter press
    sw = 10'h2A5;
    issue(0);
    clr_counters();
    enter = 1;
    steps(20);
    enter = 0;
    steps(8);
    chk("t1_in_valid_cnt", iv_cnt[0], 1);
    chk("t1_first_low_is_iv", {31'b0, first_low_iv[0]}, 1);
    chk("t1_input_data", indata_o[0], 677);

    // bouncing Enter never completes; stable press does
    sw = 10'h0F3;
    issue(0);
    clr_counters();
    for (int k = 0; k < 12; k++) begin
      enter = k[1];
      step();
    end
    chk("t2_bounce_iv", iv_cnt[0], 0);
    chk("t2_bounce_low", low_cnt[0], 0);
    enter = 1;
    steps(12);
    enter = 0;
    steps(8);
    chk("t2_in_valid_cnt", iv_cnt[0], 1);
    chk("t2_input_data", indata_o[0], 32'h0F3);

    // OUT hold of 3 and 0
    out_value = 123456;
    clr_counters();
    issue(1);
    steps(8);
    chk("t3_stall_hold3", st_cnt[0], 3);
    chk("t3_stall_hold0", st_cnt[1], 0);
    chk("t3_latch_a", latch_o[0], 123456);
    chk("t3_latch_b", latch_o[1], 123456);
    chk("t3_disp_out", {30'b0, do_o}, 3);
    chk("t3_disp_in", {30'b0, di_o}, 0);

    // Enter already down when IN arrives
    enter = 1;
    steps(10);
    sw = 10'h155;
    issue(0);
    clr_counters();
    steps(15);
    chk("t4_held_iv", iv_cnt[0], 0);
    chk("t4_held_low", low_cnt[0], 0);
    enter = 0;
    steps(8);
    enter = 1;
    steps(10);
    enter = 0;
    steps(6);
    chk("t4_in_valid_cnt", iv_cnt[0], 1);

    // HALT is terminal until reset
    issue(2);
    clr_counters();
    for (int k = 0; k < 100; k++) begin
      instr_in  = 1'($urandom);
      instr_out = 1'($urandom);
      enter     = 1'($urandom);
      sw        = 10'($urandom);
      step();
    end
    instr_in = 0; instr_out = 0; enter = 0;
    chk("t5_low", low_cnt[0] + low_cnt[1], 0);
    chk("t5_iv", iv_cnt[0] + iv_cnt[1], 0);
    chk("t5_disp_halt", {30'b0, dh_o}, 3);
    reset = 1;
    steps(2);
    reset = 0;
    #1;
    chk("t5_rst_stall", {30'b0, stall_o}, 0);
    chk("t5_rst_disp", {26'b0, dh_o, di_o, do_o}, 0);
    chk("t5_rst_latch", latch_o[0], 0);
    steps(2);

    // reset while waiting for Enter
    sw = 10'h3C3;
    issue(0);
    steps(5);
    reset = 1;
    enter = 1;
    step();
    reset = 0;
    #1;
    chk("t6_stall", {31'b0, stall_o[0]}, 0);
    chk("t6_data", indata_o[0], 0);
    clr_counters();
    steps(12);
    enter = 0;
    steps(8);
    chk("t6_iv", iv_cnt[0] + iv_cnt[1], 0);

    // random traffic
    hold = 0;
    for (int c = 0; c < 700; c++) begin
      reset      = ($urandom_range(0, 79) == 0);
      instr_halt = ($urandom_range(0, 149) == 0);
      instr_in   = ($urandom_range(0, 5) == 0);
      instr_out  = ($urandom_range(0, 5) == 0);
      sw         = 10'($urandom);
      out_value  = $urandom;
      if (hold == 0) begin
        enter = 1'($urandom);
        hold  = $urandom_range(1, 10);
      end
      hold--;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
